// File: rtl/bcd_digit_accumulator.sv
// Rebuilds a binary value from DIGIT_COUNT BCD digits, MSB digit first; optional out_sig_digits under BCD_ACCUM_SIGDIGITS_EN.
// Latency: out_valid rises DIGIT_COUNT+1 cycles after the accept cycle; one conversion in flight.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module bcd_digit_accumulator #(
  parameter int DIGIT_COUNT = 6,
  parameter int VALUE_W     = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIGIT_COUNT-1:0][3:0] in_digits,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [VALUE_W-1:0]          out_value,
  output logic                        out_error
`ifdef BCD_ACCUM_SIGDIGITS_EN
  ,
  output logic [$clog2(DIGIT_COUNT+1)-1:0] out_sig_digits
`endif
);

  localparam int IDX_W = (DIGIT_COUNT > 1) ? $clog2(DIGIT_COUNT) : 1;
  localparam int SUM_W = VALUE_W + 4;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                      state;
  logic [DIGIT_COUNT-1:0][3:0] digits_q;
  logic [VALUE_W-1:0]          acc;
  logic [IDX_W-1:0]            idx;
  logic                        bad;
  logic                        ovf;

  logic [3:0]                  cur_digit;
  logic [SUM_W-1:0]            sum;
  logic                        nxt_bad;
  logic                        nxt_ovf;
  logic [VALUE_W-1:0]          nxt_acc;

  // acc*10 as (acc<<3)+(acc<<1); four spare bits catch any overflow of one step
  always_comb begin
    cur_digit = digits_q[idx];
    sum       = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + SUM_W'(cur_digit);
    nxt_bad   = bad | (cur_digit > 4'd9);
    nxt_ovf   = ovf | (|sum[SUM_W-1:VALUE_W]);
    nxt_acc   = nxt_ovf ? '1 : sum[VALUE_W-1:0];
  end

`ifdef BCD_ACCUM_SIGDIGITS_EN
  localparam int SIG_W = $clog2(DIGIT_COUNT+1);
  logic [SIG_W-1:0] sig_cnt;

  always_comb begin
    sig_cnt = '0;
    for (int i = 0; i < DIGIT_COUNT; i++) begin
      if (digits_q[i] != 4'd0) sig_cnt = SIG_W'(i + 1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_value <= '0;
      out_error <= 1'b0;
      digits_q  <= '0;
      acc       <= '0;
      idx       <= '0;
      bad       <= 1'b0;
      ovf       <= 1'b0;
`ifdef BCD_ACCUM_SIGDIGITS_EN
      out_sig_digits <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            digits_q <= in_digits;
            acc      <= '0;
            idx      <= IDX_W'(DIGIT_COUNT - 1);
            bad      <= 1'b0;
            ovf      <= 1'b0;
            in_ready <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= nxt_acc;
          bad <= nxt_bad;
          ovf <= nxt_ovf;
          idx <= idx - IDX_W'(1);
          if (idx == '0) begin
            // a bad digit makes the whole value meaningless, so it outranks saturation
            out_value <= nxt_bad ? '0 : nxt_acc;
            out_error <= nxt_bad | nxt_ovf;
            out_valid <= 1'b1;
`ifdef BCD_ACCUM_SIGDIGITS_EN
            out_sig_digits <= sig_cnt;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_accumulator.sv
// Bench for bcd_digit_accumulator: 6-digit instances at VALUE_W=20 and VALUE_W=16, scoreboard of expected results.
module tb_bcd_digit_accumulator;

  localparam int DC = 6;
  localparam int W  = 20;
  localparam int WB = 16;
  localparam int SW = $clog2(DC + 1);

  typedef struct packed {
    logic [W-1:0]  val;
    logic          err;
    logic [SW-1:0] sig;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_valid_b;
  logic              out_ready;
  logic [DC-1:0][3:0] in_digits;
  logic              in_ready, out_valid, out_error;
  logic [W-1:0]      out_value;
  logic              in_ready_b, out_valid_b, out_error_b;
  logic [WB-1:0]     out_value_b;
`ifdef BCD_ACCUM_SIGDIGITS_EN
  logic [SW-1:0]     out_sig_digits, out_sig_digits_b;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_digit_accumulator #(.DIGIT_COUNT(DC), .VALUE_W(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_digits(in_digits),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .out_error(out_error)
`ifdef BCD_ACCUM_SIGDIGITS_EN
    , .out_sig_digits(out_sig_digits)
`endif
  );

  bcd_digit_accumulator #(.DIGIT_COUNT(DC), .VALUE_W(WB)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_digits(in_digits),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_value(out_value_b), .out_error(out_error_b)
`ifdef BCD_ACCUM_SIGDIGITS_EN
    , .out_sig_digits(out_sig_digits_b)
`endif
  );

  // Positional decimal sum, then apply bad-digit / range rules
  function automatic exp_t model(input logic [DC-1:0][3:0] d, input int w);
    exp_t   e;
    longint v    = 0;
    longint p    = 1;
    longint maxv = (longint'(1) << w) - 1;
    bit     bad  = 1'b0;
    e = '0;
    for (int i = 0; i < DC; i++) begin
      if (d[i] > 4'd9) bad = 1'b1;
      if (d[i] != 4'd0) e.sig = SW'(i + 1);
      v = v + longint'(d[i]) * p;
      p = p * 10;
    end
    if (bad) begin
      e.val = '0; e.err = 1'b1;
    end else if (v > maxv) begin
      e.val = W'(maxv); e.err = 1'b1;
    end else begin
      e.val = W'(v); e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_a(input logic [DC-1:0][3:0] d, output bit ok);
    ok        = 1'b0;
    in_digits = d;
    in_valid  = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
    end else begin
      exp_q.push_back(model(d, W));
    end
  endtask

  task automatic wait_out_a(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Called with out_valid high and out_ready high: pop, compare, step through the handshake edge
  task automatic collect_a(input string name);
    exp_t e;
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_out_valid got=%0b required 1 (queued=%0d)", name, out_valid, exp_q.size());
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (out_value !== e.val) begin
        errors++; $display("FAIL %s_value got=%0d required %0d", name, out_value, e.val);
      end
      checks++;
      if (out_error !== e.err) begin
        errors++; $display("FAIL %s_error got=%0b required %0b", name, out_error, e.err);
      end
`ifdef BCD_ACCUM_SIGDIGITS_EN
      checks++;
      if (out_sig_digits !== e.sig) begin
        errors++; $display("FAIL %s_sig got=%0d required %0d", name, out_sig_digits, e.sig);
      end
`endif
    end
    tick();
  endtask

  task automatic run_a(input logic [DC-1:0][3:0] d, input string name);
    bit ok;
    int n;
    accept_a(d, ok);
    if (ok) begin
      wait_out_a(n);
      checks++;
      if (n !== DC) begin
        errors++; $display("FAIL %s_latency got=%0d edges required %0d", name, n, DC);
      end
      collect_a(name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_valid_b = 1'b0; out_ready = 1'b1; in_digits = '0;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_value !== '0 || out_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%0b vld=%0b val=%0d err=%0b required 1 0 0 0",
               in_ready, out_valid, out_value, out_error);
    end
    checks++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || out_value_b !== '0) begin
      errors++;
      $display("FAIL reset_state_b got rdy=%0b vld=%0b val=%0d required 1 0 0", in_ready_b, out_valid_b, out_value_b);
    end
`ifdef BCD_ACCUM_SIGDIGITS_EN
    checks++;
    if (out_sig_digits !== '0) begin
      errors++; $display("FAIL reset_sig got=%0d required 0", out_sig_digits);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [DC-1:0][3:0] d;
    run_a({4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, "seq123456");
    run_a({4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9}, "all9");
    run_a('0, "zeros");
    run_a({4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7}, "units_only");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < DC; i++) d[i] = 4'($urandom_range(0, 9));
      run_a(d, "random");
    end
  endtask

  task automatic test_bad_digit();
    logic [DC-1:0][3:0] d;
    d = {4'd1, 4'd1, 4'd1, 4'hA, 4'd1, 4'd1};
    run_a(d, "bad_digit2");
    d = {4'hF, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    run_a(d, "bad_msd");
  endtask

  task automatic test_overflow();
    bit ok = 1'b0;
    int n = 0;
    exp_t e;
    in_digits  = {4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    e          = model(in_digits, WB);
    in_valid_b = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready_b) ok = 1'b1;
      tick();
    end
    in_valid_b = 1'b0;
    while (!out_valid_b && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!ok || n !== DC) begin
      errors++; $display("FAIL ovf_latency accepted=%0b got=%0d required %0d", ok, n, DC);
    end
    checks++;
    if (out_value_b !== 16'hFFFF || out_value_b !== e.val[WB-1:0]) begin
      errors++; $display("FAIL ovf_value got=%h required ffff", out_value_b);
    end
    checks++;
    if (out_error_b !== 1'b1) begin
      errors++; $display("FAIL ovf_error got=%0b required 1", out_error_b);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit   ok;
    int   n;
    exp_t e;
    out_ready = 1'b0;
    accept_a({4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9}, ok);
    wait_out_a(n);
    e = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      in_valid  = (i == 2);
      in_digits = {4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_value !== e.val || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got vld=%0b val=%0d rdy=%0b required 1 %0d 0",
                 i, out_valid, out_value, in_ready, e.val);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    collect_a("backpressure");
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_value !== e.val) begin
      errors++;
      $display("FAIL after_handshake got vld=%0b rdy=%0b val=%0d required 0 1 %0d", out_valid, in_ready, out_value, e.val);
    end
    n = 0;
    for (int i = 0; i < DC + 4; i++) begin
      tick();
      if (out_valid) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL ignored_input got=%0d output cycles required 0", n);
    end
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    int n;
    int t0 = 0;
    int t1 = 0;
    in_digits = {4'd0, 4'd4, 4'd2, 4'd0, 4'd4, 4'd2};
    in_valid  = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) begin ok = 1'b1; t0 = cyc; end
      tick();
    end
    exp_q.push_back(model(in_digits, W));
    in_digits = {4'd8, 4'd6, 4'd7, 4'd5, 4'd3, 4'd0};
    wait_out_a(n);
    collect_a("b2b_first");
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (in_ready) begin ok = 1'b1; t1 = cyc; end
      tick();
    end
    in_valid = 1'b0;
    exp_q.push_back(model(in_digits, W));
    checks++;
    if (!ok || (t1 - t0) !== DC + 2) begin
      errors++; $display("FAIL b2b_spacing got=%0d required %0d", t1 - t0, DC + 2);
    end
    wait_out_a(n);
    collect_a("b2b_second");
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    accept_a({4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5}, ok);
    void'(exp_q.pop_back());
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_value !== '0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%0b vld=%0b val=%0d required 1 0 0", in_ready, out_valid, out_value);
    end
    for (int i = 0; i < DC + 4; i++) begin
      tick();
      if (out_valid) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++; $display("FAIL reset_mid_no_output got=%0d output cycles required 0", n);
    end
  endtask

`ifdef BCD_ACCUM_SIGDIGITS_EN
  task automatic test_sigdigits();
    bit ok;
    int n;
    accept_a({4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd1}, ok);
    wait_out_a(n);
    checks++;
    if (out_sig_digits !== SW'(4)) begin
      errors++; $display("FAIL sigdigits got=%0d required 4", out_sig_digits);
    end
    collect_a("sigdigits");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_digit();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef BCD_ACCUM_SIGDIGITS_EN
    test_sigdigits();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover got=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
